mnist_train_sched: RTL and testbench

//  Training sequencer for the ten one-vs-rest pseudo-linear MNIST classifiers (classes 0..9).

---
 rtl/mnist_pkg.sv | 30 +++
 rtl/mnist_train_sched_lfsr.sv | 34 +++
 rtl/mnist_train_sched.sv | 194 +++++++++++++++++++
 tb/tb_mnist_train_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared constants for the MNIST training sequencer: image layout, FSM state codes
// and the argmax helper used to turn classifier results into a class index.
package mnist_pkg;

    localparam int N_PIX   = 784;
    localparam int N_CLASS = 10;
    localparam int IMG_W   = 794;
    localparam int LBL_LSB = 0;
    localparam int PIX_LSB = 10;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_FETCH     = 3'd1;
    localparam state_t S_WAIT      = 3'd2;
    localparam state_t S_APPLY     = 3'd3;
    localparam state_t S_EPOCH_END = 3'd4;
    localparam state_t S_FIN       = 3'd5;

    // Lowest set class wins; 4'hF means no classifier fired.
    function automatic logic [3:0] first_set(input logic [N_CLASS-1:0] v);
        logic [3:0] r;
        r = 4'hF;
        for (int k = N_CLASS - 1; k >= 0; k--) begin
            if (v[k]) r = 4'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/mnist_train_sched_lfsr.sv
// 16-bit maximal-length Fibonacci LFSR, x^16+x^14+x^13+x^11+1, with load and step enables.
module lfsr_16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign value = state_q;

endmodule

// File: rtl/mnist_train_sched.sv
// Training sequencer: fetches each sample, presents it to the ten classifiers for one
// update cycle, tracks per-epoch errors and the argmax prediction, and stops early on a clean epoch.
module mnist_train_sched
    import mnist_pkg::*;
#(
    parameter int          N_SAMPLES = 60000,
    parameter int          AW        = 16,
    parameter int          SHUFFLE   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          cfg_epochs,
    input  logic [3:0]           cfg_threshold,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_req,
    output logic [AW-1:0]        mem_addr,
    input  logic                 mem_valid,
    input  logic [IMG_W-1:0]     mem_data,
    output logic [N_PIX-1:0]     img_pix,
    output logic [N_CLASS-1:0]   img_label,
    output logic [3:0]           threshold,
    input  logic [N_CLASS-1:0]   cls_result,
    output logic [15:0]          epoch_cnt,
    output logic [AW:0]          epoch_err,
    output logic                 err_valid,
    output logic [3:0]           pred_class,
    output logic                 pred_valid
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMPLES - 1);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW:0]   ERR_ONE  = (AW + 1)'(1);

    state_t               state_q, state_d;
    logic [15:0]          epochs_lim_q, epochs_lim_d;
    logic [3:0]           thr_q, thr_d;
    logic [AW-1:0]        sample_cnt_q, sample_cnt_d;
    logic [AW:0]          err_cnt_q, err_cnt_d;
    logic [15:0]          epoch_cnt_q, epoch_cnt_d;
    logic [AW:0]          epoch_err_q, epoch_err_d;
    logic                 err_valid_q, err_valid_d;
    logic [3:0]           pred_class_q, pred_class_d;
    logic                 pred_valid_q, pred_valid_d;
    logic [IMG_W-1:0]     sample_q, sample_d;

    logic                 lfsr_load;
    logic                 lfsr_step;
    logic [15:0]          lfsr_val;
    logic [15:0]          lfsr_unused;
    logic [AW-1:0]        cand;
    logic                 cand_ok;
    logic [15:0]          epoch_inc;
    logic                 apply;

    lfsr_16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    assign lfsr_unused = lfsr_val;
    assign cand        = lfsr_val[AW-1:0];
    assign cand_ok     = 32'(cand) < 32'(N_SAMPLES);
    assign epoch_inc   = (epoch_cnt_q == 16'hFFFF) ? epoch_cnt_q : epoch_cnt_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        epochs_lim_d = epochs_lim_q;
        thr_d        = thr_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        epoch_cnt_d  = epoch_cnt_q;
        epoch_err_d  = epoch_err_q;
        err_valid_d  = 1'b0;
        pred_class_d = pred_class_q;
        pred_valid_d = 1'b0;
        sample_d     = sample_q;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    epochs_lim_d = cfg_epochs;
                    thr_d        = cfg_threshold;
                    sample_cnt_d = '0;
                    err_cnt_d    = '0;
                    epoch_cnt_d  = '0;
                    lfsr_load    = 1'b1;
                    state_d      = (cfg_epochs == 16'd0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (SHUFFLE != 0) begin
                    // Out-of-range LFSR values are skipped without issuing a request.
                    lfsr_step = 1'b1;
                    if (cand_ok) begin
                        mem_req  = 1'b1;
                        mem_addr = cand;
                        state_d  = S_WAIT;
                    end
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = sample_cnt_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_valid) begin
                    sample_d = mem_data;
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
                // cls_result still reflects the pre-update parameters here.
                pred_class_d = first_set(cls_result);
                pred_valid_d = 1'b1;
                if (cls_result != sample_q[PIX_LSB-1:LBL_LSB]) begin
                    err_cnt_d = err_cnt_q + ERR_ONE;
                end
                if (sample_cnt_q == LAST_IDX) begin
                    sample_cnt_d = '0;
                    state_d      = S_EPOCH_END;
                end else begin
                    sample_cnt_d = sample_cnt_q + CNT_ONE;
                    state_d      = S_FETCH;
                end
            end
            S_EPOCH_END: begin
                epoch_err_d = err_cnt_q;
                err_valid_d = 1'b1;
                epoch_cnt_d = epoch_inc;
                err_cnt_d   = '0;
                state_d     = (err_cnt_q == '0 || epoch_inc == epochs_lim_q) ? S_FIN : S_FETCH;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            epochs_lim_q <= '0;
            thr_q        <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            epoch_cnt_q  <= '0;
            epoch_err_q  <= '0;
            err_valid_q  <= 1'b0;
            pred_class_q <= '0;
            pred_valid_q <= 1'b0;
            sample_q     <= '0;
        end else begin
            state_q      <= state_d;
            epochs_lim_q <= epochs_lim_d;
            thr_q        <= thr_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            epoch_cnt_q  <= epoch_cnt_d;
            epoch_err_q  <= epoch_err_d;
            err_valid_q  <= err_valid_d;
            pred_class_q <= pred_class_d;
            pred_valid_q <= pred_valid_d;
            sample_q     <= sample_d;
        end
    end

    // The classifiers see a zero image in every cycle but APPLY, so they never update then.
    assign apply      = (state_q == S_APPLY);
    assign img_pix    = apply ? sample_q[IMG_W-1:PIX_LSB] : '0;
    assign img_label  = apply ? sample_q[PIX_LSB-1:LBL_LSB] : '0;
    assign busy       = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                        (state_q == S_APPLY) || (state_q == S_EPOCH_END);
    assign done       = (state_q == S_FIN);
    assign threshold  = thr_q;
    assign epoch_cnt  = epoch_cnt_q;
    assign epoch_err  = epoch_err_q;
    assign err_valid  = err_valid_q;
    assign pred_class = pred_class_q;
    assign pred_valid = pred_valid_q;

endmodule

// File: tb/tb_mnist_train_sched.sv
// Scoreboard bench: two sequencer instances (sequential N=4, shuffled N=5) with modelled
// sample memories and classifiers; expected addresses, predictions and epoch results are queued.
module tb_mnist_train_sched;

    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          start0, busy0, done0, mem_req0, mem_valid0, err_valid0, pred_valid0;
    logic [15:0]   cfg_epochs0, epoch_cnt0;
    logic [3:0]    cfg_thr0, threshold0, pred_class0;
    logic [AW-1:0] mem_addr0;
    logic [793:0]  mem_data0;
    logic [783:0]  img_pix0;
    logic [9:0]    img_label0, cls_result0;
    logic [AW:0]   epoch_err0;

    logic          start1, busy1, done1, mem_req1, mem_valid1, err_valid1, pred_valid1;
    logic [15:0]   cfg_epochs1, epoch_cnt1;
    logic [3:0]    cfg_thr1, threshold1, pred_class1;
    logic [AW-1:0] mem_addr1;
    logic [793:0]  mem_data1;
    logic [783:0]  img_pix1;
    logic [9:0]    img_label1, cls_result1;
    logic [AW:0]   epoch_err1;

    int cls_mode;
    assign cls_result0 = (cls_mode == 0) ? img_label0 :
                         (cls_mode == 1) ? 10'h000 : 10'b0000101000;
    assign cls_result1 = 10'h000;

    mnist_train_sched #(.N_SAMPLES(4), .AW(AW), .SHUFFLE(0), .LFSR_SEED(16'hACE1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cfg_epochs(cfg_epochs0),
        .cfg_threshold(cfg_thr0), .busy(busy0), .done(done0), .mem_req(mem_req0),
        .mem_addr(mem_addr0), .mem_valid(mem_valid0), .mem_data(mem_data0),
        .img_pix(img_pix0), .img_label(img_label0), .threshold(threshold0),
        .cls_result(cls_result0), .epoch_cnt(epoch_cnt0), .epoch_err(epoch_err0),
        .err_valid(err_valid0), .pred_class(pred_class0), .pred_valid(pred_valid0)
    );

    mnist_train_sched #(.N_SAMPLES(5), .AW(AW), .SHUFFLE(1), .LFSR_SEED(16'hACE1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cfg_epochs(cfg_epochs1),
        .cfg_threshold(cfg_thr1), .busy(busy1), .done(done1), .mem_req(mem_req1),
        .mem_addr(mem_addr1), .mem_valid(mem_valid1), .mem_data(mem_data1),
        .img_pix(img_pix1), .img_label(img_label1), .threshold(threshold1),
        .cls_result(cls_result1), .epoch_cnt(epoch_cnt1), .epoch_err(epoch_err1),
        .err_valid(err_valid1), .pred_class(pred_class1), .pred_valid(pred_valid1)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [783:0] pix_of(input int a);
        logic [7:0] b;
        b = 8'(a * 16 + 5);
        return {98{b}};
    endfunction

    function automatic logic [9:0] lbl_of(input int a);
        case (a)
            0:       return 10'b0000000001;
            1:       return 10'b0000001000;
            2:       return 10'b1000000000;
            3:       return 10'b0000101000;
            default: return 10'b0000000001;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    int exp_addr0[$], exp_pred0[$], exp_err0[$], exp_ecnt0[$];
    int exp_addr1[$], exp_err1[$], exp_ecnt1[$];
    int last_addr0 = 0;
    int apply_cnt0 = 0;
    int req_cnt1 = 0;

    // Memory models: latency 3 for instance 0, 2 for instance 1; a reset cancels a pending read.
    initial begin
        mem_valid0 = 1'b0;
        mem_data0  = '0;
        forever begin
            @(negedge clk);
            if (mem_req0) begin
                int a;
                a = int'(mem_addr0);
                repeat (3) @(posedge clk);
                if (rst_n) begin
                    #1 mem_valid0 = 1'b1;
                    mem_data0 = {pix_of(a), lbl_of(a)};
                    @(posedge clk);
                    #1 mem_valid0 = 1'b0;
                    mem_data0 = '0;
                end
            end
        end
    end

    initial begin
        mem_valid1 = 1'b0;
        mem_data1  = '0;
        forever begin
            @(negedge clk);
            if (mem_req1) begin
                int a;
                a = int'(mem_addr1);
                repeat (2) @(posedge clk);
                #1 mem_valid1 = 1'b1;
                mem_data1 = {pix_of(a), lbl_of(a)};
                @(posedge clk);
                #1 mem_valid1 = 1'b0;
                mem_data1 = '0;
            end
        end
    end

    always @(negedge clk) begin
        int e;
        if (mem_req0) begin
            if (exp_addr0.size() == 0) begin
                total++; bad++;
                $display("FAIL addr0_unexpected: got %0d expected no request", mem_addr0);
            end else begin
                e = exp_addr0.pop_front();
                check("mem_addr0", int'(mem_addr0), e);
            end
            last_addr0 = int'(mem_addr0);
        end
        if (img_pix0 != '0) begin
            apply_cnt0++;
            check("img_pix0", int'(img_pix0 == pix_of(last_addr0)), 1);
            check("img_label0", int'(img_label0), int'(lbl_of(last_addr0)));
        end else if (img_label0 != '0) begin
            check("img_label0_idle", int'(img_label0), 0);
        end
        if (pred_valid0) begin
            if (exp_pred0.size() == 0) begin
                total++; bad++;
                $display("FAIL pred0_unexpected: got %0d expected none", pred_class0);
            end else begin
                e = exp_pred0.pop_front();
                check("pred_class0", int'(pred_class0), e);
            end
        end
        if (err_valid0) begin
            if (exp_err0.size() == 0) begin
                total++; bad++;
                $display("FAIL err0_unexpected: got %0d expected none", epoch_err0);
            end else begin
                e = exp_err0.pop_front();
                check("epoch_err0", int'(epoch_err0), e);
                e = exp_ecnt0.pop_front();
                check("epoch_cnt0", int'(epoch_cnt0), e);
            end
        end
    end

    always @(negedge clk) begin
        int e;
        if (mem_req1) begin
            req_cnt1++;
            check("addr1_range", int'(mem_addr1 < 3'd5), 1);
            if (exp_addr1.size() == 0) begin
                total++; bad++;
                $display("FAIL addr1_unexpected: got %0d expected no request", mem_addr1);
            end else begin
                e = exp_addr1.pop_front();
                check("mem_addr1", int'(mem_addr1), e);
            end
        end
        if (err_valid1) begin
            if (exp_err1.size() == 0) begin
                total++; bad++;
                $display("FAIL err1_unexpected: got %0d expected none", epoch_err1);
            end else begin
                e = exp_err1.pop_front();
                check("epoch_err1", int'(epoch_err1), e);
                e = exp_ecnt1.pop_front();
                check("epoch_cnt1", int'(epoch_cnt1), e);
            end
        end
    end

    task automatic pulse_start0(input logic [15:0] ep, input logic [3:0] thr);
        @(posedge clk);
        #1 start0 = 1'b1;
        cfg_epochs0 = ep;
        cfg_thr0 = thr;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    task automatic pulse_start1(input logic [15:0] ep);
        @(posedge clk);
        #1 start1 = 1'b1;
        cfg_epochs1 = ep;
        cfg_thr1 = 4'd2;
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int limit, input string name);
        int n;
        n = 0;
        while (((which == 0) ? done0 : done1) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, int'((which == 0) ? done0 : done1), 1);
    endtask

    initial begin
        int base;
        int n;
        int v;
        logic [15:0] s;

        rst_n = 1'b0;
        start0 = 1'b0; cfg_epochs0 = '0; cfg_thr0 = '0;
        start1 = 1'b0; cfg_epochs1 = '0; cfg_thr1 = '0;
        cls_mode = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", int'(busy0), 0);
        check("reset_done", int'(done0), 0);
        check("reset_epoch_cnt", int'(epoch_cnt0), 0);

        // Reset while waiting on memory, then restart from address 0.
        exp_addr0.push_back(0);
        pulse_start0(16'd2, 4'd7);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_wait_busy", int'(busy0), 0);
        check("rst_wait_mem_req", int'(mem_req0), 0);
        check("rst_wait_mem_addr", int'(mem_addr0), 0);
        check("rst_wait_threshold", int'(threshold0), 0);
        check("rst_wait_img", int'(img_pix0 == '0 && img_label0 == '0), 1);
        check("rst_wait_flags", int'({done0, err_valid0, pred_valid0}), 0);
        check("rst_wait_pred_class", int'(pred_class0), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two epochs, all classifiers silent: 4 errors per epoch, no prediction.
        cls_mode = 1;
        for (int e = 1; e <= 2; e++) begin
            for (int a = 0; a < 4; a++) begin
                exp_addr0.push_back(a);
                exp_pred0.push_back(15);
            end
            exp_err0.push_back(4);
            exp_ecnt0.push_back(e);
        end
        base = apply_cnt0;
        pulse_start0(16'd2, 4'd9);
        @(negedge clk);
        check("t2_busy", int'(busy0), 1);
        check("t2_threshold", int'(threshold0), 9);
        wait_done(0, 300, "t2_done");
        check("t2_busy_at_done", int'(busy0), 0);
        @(negedge clk);
        check("t2_apply_cycles", apply_cnt0 - base, 8);
        check("t2_queues_empty", exp_addr0.size() + exp_pred0.size() + exp_err0.size(), 0);
        check("t2_epoch_cnt", int'(epoch_cnt0), 2);

        // Perfect classifiers: clean first epoch stops the run early.
        cls_mode = 0;
        for (int a = 0; a < 4; a++) exp_addr0.push_back(a);
        exp_pred0.push_back(0); exp_pred0.push_back(3);
        exp_pred0.push_back(9); exp_pred0.push_back(3);
        exp_err0.push_back(0);
        exp_ecnt0.push_back(1);
        base = apply_cnt0;
        pulse_start0(16'd5, 4'd3);
        wait_done(0, 300, "t3_done");
        @(negedge clk);
        check("t3_epoch_cnt", int'(epoch_cnt0), 1);
        check("t3_apply_cycles", apply_cnt0 - base, 4);
        check("t3_queues_empty", exp_addr0.size() + exp_pred0.size() + exp_err0.size(), 0);

        // Fixed result 0000101000: prediction 3, only the sample with that label matches.
        cls_mode = 2;
        for (int a = 0; a < 4; a++) begin
            exp_addr0.push_back(a);
            exp_pred0.push_back(3);
        end
        exp_err0.push_back(3);
        exp_ecnt0.push_back(1);
        pulse_start0(16'd1, 4'd5);
        for (int i = 0; i < 3; i++) pulse_start0(16'd3, 4'd1);
        @(negedge clk);
        check("t5_threshold_kept", int'(threshold0), 5);
        wait_done(0, 300, "t5_done");
        @(negedge clk);
        check("t5_idle_after", int'(busy0), 0);
        check("t5_epoch_err", int'(epoch_err0), 3);
        check("t5_queues_empty", exp_addr0.size() + exp_pred0.size() + exp_err0.size(), 0);

        // Shuffled fetch order on the N=5 instance.
        s = 16'hACE1;
        n = 0;
        while (n < 10) begin
            v = int'(s[2:0]);
            s = lfsr_adv(s);
            if (v < 5) begin
                exp_addr1.push_back(v);
                n++;
            end
        end
        exp_err1.push_back(5); exp_ecnt1.push_back(1);
        exp_err1.push_back(5); exp_ecnt1.push_back(2);
        base = req_cnt1;
        pulse_start1(16'd2);
        wait_done(1, 600, "t6_done");
        @(negedge clk);
        check("t6_req_count", req_cnt1 - base, 10);
        check("t6_queues_empty", exp_addr1.size() + exp_err1.size(), 0);

        // Zero epochs: done without any memory traffic.
        base = req_cnt1;
        pulse_start1(16'd0);
        wait_done(1, 5, "t6_zero_done");
        check("t6_zero_busy", int'(busy1), 0);
        repeat (3) @(negedge clk);
        check("t6_zero_no_req", req_cnt1 - base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
